neopixel_load_sequencer: RTL and testbench
==========================================

Name: neopixel_load_sequencer

Overview:
- Command sequencer that programs an external NeoPixel controller; the controller itself is outside this block.
- Steps through a fixed 3-entry table of colour writes, issuing one load_color per entry when the controller reports ready_to_load.
- After the third write, waits for ready_to_send, pulses send_it once, then parks until reset.
- Sits between the board-level start logic and the NeoPixel controller's load/send interface.

Parameters:
- NUM_LOADS, 3, number of table entries written before send (fixed; table below is sized to it)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- ready_to_load  input  1  controller can accept a load_color this cycle
- ready_to_send  input  1  controller can accept send_it this cycle
- neo_data  input  1  controller serial output; monitor-only, no logic depends on it
- load_color  output  1  write strobe; fields below are valid while high
- send_it  output  1  one-cycle request to transmit the loaded frame
- pixel_index  output  3  target pixel, 0..4 used
- color_index  output  2  0=green, 1=red, 2=blue; 3 never driven
- color_level  output  8  intensity byte

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, ports named clock and reset.
- Registered state currstate, combinational nextstate, enumerated LOAD, SEND, DONE.
- Entry counter entry[1:0] is registered.
- Reset (asynchronous, any time, including mid-sequence): currstate=LOAD, entry=0, load_color=0, send_it=0.
- Outputs are combinational from state, entry and the ready inputs; a strobe goes high in the same cycle as its enabling input.
- Table, indexed by entry (pixel, colour, level):
  - 0 = (0, 0, 0x80)
  - 1 = (1, 1, 0x40)
  - 2 = (4, 2, 0xFF)
- pixel_index, color_index and color_level always show table[entry] in LOAD.
- In SEND and DONE they show table[2].
- LOAD:
  - load_color = ready_to_load.
  - On a clock edge with ready_to_load=1, entry increments.
  - If entry==NUM_LOADS-1, nextstate=SEND and entry holds at 2.
  - ready_to_load=0 stalls: no strobe, no advance.
  - ready_to_send is ignored in LOAD.
- SEND:
  - load_color=0; send_it = ready_to_send.
  - On an edge with ready_to_send=1, nextstate=DONE.
  - Otherwise wait indefinitely.
  - ready_to_load is ignored.
- DONE: all strobes 0, terminal until reset; inputs ignored.
- load_color and send_it are never high in the same cycle.
- Exactly NUM_LOADS load strobes and one send strobe per reset.

Test Plan:
- Reset high, then ready_to_load=0 and ready_to_send=0 for 3 cycles -> currstate=LOAD, entry=0, load_color=0, send_it=0.
- ready_to_load=1 for 3 consecutive cycles -> load_color=1 each cycle with fields (0,0,0x80), (1,1,0x40), (4,2,0xFF); then currstate=SEND.
- ready_to_send=1 during the 2nd load cycle -> send_it stays 0; the load still occurs.
- In SEND, ready_to_load=0, ready_to_send=1 for one cycle -> send_it=1 for exactly that cycle; currstate=DONE next cycle.
- DONE for 1000 cycles with both ready inputs toggling -> no strobes.
- Reset asserted mid-LOAD after 1 write -> immediately LOAD, entry=0; the sequence restarts at (0,0,0x80).
- Gaps in ready_to_load between writes -> entries still issued in order with no skips or duplicates.

Source files
------------

// File: rtl/neopixel_load_sequencer.sv
// neopixel_load_sequencer
// Programs an external NeoPixel controller: writes a fixed three-entry colour
// table with load_color, waits for the controller to accept send_it once,
// then parks in DONE until the next reset.
module neopixel_load_sequencer #(
    parameter int NUM_LOADS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ready_to_load,
    input  logic       ready_to_send,
    input  logic       neo_data,
    output logic       load_color,
    output logic       send_it,
    output logic [2:0] pixel_index,
    output logic [1:0] color_index,
    output logic [7:0] color_level
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] LAST_ENTRY = 2'(NUM_LOADS - 1);

    state_t     currstate;
    state_t     nextstate;
    logic [1:0] entry;
    logic [1:0] entry_next;
    logic [1:0] table_idx;

    // The controller's serial output is only brought in for board-level probing.
    logic neo_data_unused;
    assign neo_data_unused = neo_data;

    // Next-state and entry-advance decision from the current state and ready inputs.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        nextstate  = currstate;
        entry_next = entry;
        case (currstate)
            LOAD: begin
                if (ready_to_load) begin
                    if (entry == LAST_ENTRY) begin
                        nextstate = SEND;
                    end else begin
                        entry_next = entry + 2'd1;
                    end
                end
            end
            SEND: begin
                if (ready_to_send) begin
                    nextstate = DONE;
                end
            end
            default: begin
                nextstate = DONE;
            end
        endcase
    end

    // State and entry registers; reset restarts the sequence from the first entry.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) begin
            currstate <= LOAD;
            entry     <= 2'd0;
        end else begin
            currstate <= nextstate;
            entry     <= entry_next;
        end
    end

    // Strobes follow their enabling ready input in the same cycle; held low in reset.
    always_comb begin
        load_color = 1'b0;
        send_it    = 1'b0;
        if (!reset) begin
            case (currstate)
                LOAD:    load_color = ready_to_load;
                SEND:    send_it    = ready_to_send;
                default: ;
            endcase
        end
    end

    // Fields show the entry being written in LOAD, and the last entry afterwards.
    always_comb begin
        table_idx = (currstate == LOAD) ? entry : LAST_ENTRY;
        case (table_idx)
            2'd0: begin
                pixel_index = 3'd0;
                color_index = 2'd0;
                color_level = 8'h80;
            end
            2'd1: begin
                pixel_index = 3'd1;
                color_index = 2'd1;
                color_level = 8'h40;
            end
            default: begin
                pixel_index = 3'd4;
                color_index = 2'd2;
                color_level = 8'hFF;
            end
        endcase
    end

endmodule

// File: tb/tb_neopixel_load_sequencer.sv
// tb_neopixel_load_sequencer
// Scoreboard bench: the driver pushes the expected per-cycle outputs from a
// small reference model, and a negedge monitor pops and compares them.
module tb_neopixel_load_sequencer;

    logic       clock;
    logic       reset;
    logic       ready_to_load;
    logic       ready_to_send;
    logic       neo_data;
    logic       load_color;
    logic       send_it;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;

    neopixel_load_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .ready_to_load (ready_to_load),
        .ready_to_send (ready_to_send),
        .neo_data      (neo_data),
        .load_color    (load_color),
        .send_it       (send_it),
        .pixel_index   (pixel_index),
        .color_index   (color_index),
        .color_level   (color_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       load;
        logic       send;
        logic [2:0] pix;
        logic [1:0] col;
        logic [7:0] lvl;
        logic [1:0] st;
        logic [1:0] ent;
    } exp_t;

    exp_t sb[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int n_loads      = 0;
    int n_sends      = 0;

    // Reference model: 0=LOAD, 1=SEND, 2=DONE.
    logic [1:0] m_state;
    logic [1:0] m_entry;
    logic [2:0] t_pix [3];
    logic [1:0] t_col [3];
    logic [7:0] t_lvl [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; pushes the expectation for that cycle.
    task automatic drive(input logic rl, input logic rs);
        exp_t e;
        int   idx;
        @(posedge clock);
        #1;
        ready_to_load = rl;
        ready_to_send = rs;
        idx    = (m_state == 2'd0) ? int'(m_entry) : 2;
        e.pix  = t_pix[idx];
        e.col  = t_col[idx];
        e.lvl  = t_lvl[idx];
        e.st   = m_state;
        e.ent  = m_entry;
        e.load = (m_state == 2'd0) && rl;
        e.send = (m_state == 2'd1) && rs;
        sb.push_back(e);
        case (m_state)
            2'd0: if (rl) begin
                if (m_entry == 2'd2) m_state = 2'd1;
                else m_entry = m_entry + 2'd1;
            end
            2'd1: if (rs) m_state = 2'd2;
            default: ;
        endcase
    endtask

    // Asynchronous reset between edges, with ready_to_load high to show gating.
    task automatic apply_reset();
        @(negedge clock);
        #2;
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        reset = 1'b1;
        #1;
        check("rst_load_color", 32'(load_color), 32'd0);
        check("rst_send_it", 32'(send_it), 32'd0);
        check("rst_state", 32'(dut.currstate), 32'd0);
        check("rst_entry", 32'(dut.entry), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2;
        ready_to_load = 1'b0;
        ready_to_send = 1'b0;
        reset   = 1'b0;
        m_state = 2'd0;
        m_entry = 2'd0;
    endtask

    // Monitor: compare DUT outputs against the scoreboard away from the active edge.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("load_color", 32'(load_color), 32'(e.load));
            check("send_it", 32'(send_it), 32'(e.send));
            check("exclusive", 32'(load_color & send_it), 32'd0);
            check("pixel_index", 32'(pixel_index), 32'(e.pix));
            check("color_index", 32'(color_index), 32'(e.col));
            check("color_level", 32'(color_level), 32'(e.lvl));
            check("currstate", 32'(dut.currstate), 32'(e.st));
            check("entry", 32'(dut.entry), 32'(e.ent));
            if (load_color) n_loads++;
            if (send_it) n_sends++;
        end
    end

    initial begin
        t_pix[0] = 3'd0; t_col[0] = 2'd0; t_lvl[0] = 8'h80;
        t_pix[1] = 3'd1; t_col[1] = 2'd1; t_lvl[1] = 8'h40;
        t_pix[2] = 3'd4; t_col[2] = 2'd2; t_lvl[2] = 8'hFF;
        neo_data      = 1'b0;
        ready_to_load = 1'b0;
        ready_to_send = 1'b0;
        m_state       = 2'd0;
        m_entry       = 2'd0;

        // Power-on reset.
        reset = 1'b1;
        #1;
        ready_to_load = 1'b1;
        #1;
        check("por_load_color", 32'(load_color), 32'd0);
        check("por_state", 32'(dut.currstate), 32'd0);
        check("por_entry", 32'(dut.entry), 32'd0);
        @(negedge clock);
        #2;
        ready_to_load = 1'b0;
        reset = 1'b0;

        // Idle: nothing happens without ready_to_load.
        repeat (3) drive(1'b0, 1'b0);

        // One write, then reset mid-LOAD.
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        apply_reset();

        // Gapped writes; ready_to_send ignored in LOAD, ready_to_load ignored in SEND.
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        apply_reset();

        // Back-to-back writes with ready_to_send during the second, then send.
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);

        // DONE is terminal whatever the ready inputs do.
        for (int i = 0; i < 1000; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(posedge clock);
        @(negedge clock);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("total_loads", 32'(n_loads), 32'd7);
        check("total_sends", 32'(n_sends), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
